audio_pipeline_axil_regs: RTL and testbench

AXI4-Lite responder (slave) register file that terminates the control interface of the audio pipeline IP. It accepts single-beat 32-bit writes and reads from the PS/VIP master and exposes NUM_REGS read/write control words to the pipeline datapath. It also produces per-register write strobes. It is the far end of the master that drives the IP's S00_AXI port.

---
 rtl/audio_pipeline_axil_regs_if.sv | 51 +++++
 rtl/audio_pipeline_axil_regs.sv | 175 +++++++++++++++++
 tb/tb_audio_pipeline_axil_regs.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_pipeline_axil_regs_if.sv
// AXI4-Lite control channel bundle for the audio pipeline register file.
// The slave modport is the register-file side; master is the PS/VIP side.
interface audio_pipeline_axil_regs_if #(
   parameter int ADDR_WIDTH = 4
);
   logic [ADDR_WIDTH-1:0] s_axi_awaddr;
   logic [2:0]            s_axi_awprot;
   logic                  s_axi_awvalid;
   logic                  s_axi_awready;
   logic [31:0]           s_axi_wdata;
   logic [3:0]            s_axi_wstrb;
   logic                  s_axi_wvalid;
   logic                  s_axi_wready;
   logic [1:0]            s_axi_bresp;
   logic                  s_axi_bvalid;
   logic                  s_axi_bready;
   logic [ADDR_WIDTH-1:0] s_axi_araddr;
   logic [2:0]            s_axi_arprot;
   logic                  s_axi_arvalid;
   logic                  s_axi_arready;
   logic [31:0]           s_axi_rdata;
   logic [1:0]            s_axi_rresp;
   logic                  s_axi_rvalid;
   logic                  s_axi_rready;

   modport slave (
      input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
      output s_axi_awready,
      input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
      output s_axi_wready,
      output s_axi_bresp, s_axi_bvalid,
      input  s_axi_bready,
      input  s_axi_araddr, s_axi_arprot, s_axi_arvalid,
      output s_axi_arready,
      output s_axi_rdata, s_axi_rresp, s_axi_rvalid,
      input  s_axi_rready
   );

   modport master (
      output s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
      input  s_axi_awready,
      output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
      input  s_axi_wready,
      input  s_axi_bresp, s_axi_bvalid,
      output s_axi_bready,
      output s_axi_araddr, s_axi_arprot, s_axi_arvalid,
      input  s_axi_arready,
      input  s_axi_rdata, s_axi_rresp, s_axi_rvalid,
      output s_axi_rready
   );
endinterface

// File: rtl/audio_pipeline_axil_regs.sv
// AXI4-Lite register file terminating the audio pipeline control port.
// Define AXIL_REGS_SLVERR_EN to answer out-of-range accesses with SLVERR.
module audio_pipeline_axil_regs #(
   parameter int          ADDR_WIDTH  = 4,
   parameter int          NUM_REGS    = 4,
   parameter logic [31:0] RESET_VALUE = 32'h0
) (
   input  logic                      ACLK,
   input  logic                      ARESETN,
   audio_pipeline_axil_regs_if.slave axil,
   output logic [NUM_REGS*32-1:0]    reg_out,
   output logic [NUM_REGS-1:0]       reg_wr_stb
);

   localparam int IDX_W = ADDR_WIDTH - 2;
   localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REGS_SLVERR_EN
   localparam logic [1:0] RESP_OOR = 2'b10;
`else
   localparam logic [1:0] RESP_OOR = 2'b00;
`endif

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   w_state_t w_state, w_state_nxt;
   r_state_t r_state, r_state_nxt;

   logic [31:0]      regs [NUM_REGS];
   logic             aw_held, w_held;
   logic [IDX_W-1:0] aw_idx_q;
   logic [31:0]      wdata_q;
   logic [3:0]       wstrb_q;

   logic             aw_fire, w_fire, wr_done, ar_fire;
   logic [IDX_W-1:0] wr_idx, rd_idx;
   logic [31:0]      wr_data, rd_word;
   logic [3:0]       wr_strb;
   logic             wr_in_range, rd_in_range;

   logic unused_ok;
   assign unused_ok = ^{axil.s_axi_awprot, axil.s_axi_arprot,
                        axil.s_axi_awaddr[1:0], axil.s_axi_araddr[1:0]};

   // Readies depend only on state, never on the incoming valids.
   assign aw_fire = axil.s_axi_awvalid && (w_state == W_IDLE) && !aw_held;
   assign w_fire  = axil.s_axi_wvalid  && (w_state == W_IDLE) && !w_held;

   assign wr_idx  = aw_held ? aw_idx_q : axil.s_axi_awaddr[ADDR_WIDTH-1:2];
   assign wr_data = w_held  ? wdata_q  : axil.s_axi_wdata;
   assign wr_strb = w_held  ? wstrb_q  : axil.s_axi_wstrb;
   assign rd_idx  = axil.s_axi_araddr[ADDR_WIDTH-1:2];

   assign wr_in_range = int'(wr_idx) < NUM_REGS;
   assign rd_in_range = int'(rd_idx) < NUM_REGS;

   // NOTE: state registers use non-blocking assignment so every flop samples
   // the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         w_state <= W_IDLE;
         r_state <= R_IDLE;
      end else begin
         w_state <= w_state_nxt;
         r_state <= r_state_nxt;
      end
   end

   // NOTE: every output of this block gets a default first so no latch is
   // inferred on any path through the case.
   always_comb begin
      w_state_nxt        = w_state;
      wr_done            = 1'b0;
      axil.s_axi_awready = 1'b0;
      axil.s_axi_wready  = 1'b0;
      axil.s_axi_bvalid  = 1'b0;
      case (w_state)
         W_IDLE: begin
            axil.s_axi_awready = !aw_held;
            axil.s_axi_wready  = !w_held;
            if ((aw_held || aw_fire) && (w_held || w_fire)) begin
               wr_done     = 1'b1;
               w_state_nxt = W_RESP;
            end
         end
         W_RESP: begin
            axil.s_axi_bvalid = 1'b1;
            if (axil.s_axi_bready) w_state_nxt = W_IDLE;
         end
      endcase
   end

   always_comb begin
      r_state_nxt        = r_state;
      ar_fire            = 1'b0;
      axil.s_axi_arready = 1'b0;
      axil.s_axi_rvalid  = 1'b0;
      case (r_state)
         R_IDLE: begin
            axil.s_axi_arready = 1'b1;
            if (axil.s_axi_arvalid) begin
               ar_fire     = 1'b1;
               r_state_nxt = R_DATA;
            end
         end
         R_DATA: begin
            axil.s_axi_rvalid = 1'b1;
            if (axil.s_axi_rready) r_state_nxt = R_IDLE;
         end
      endcase
   end

   // Out-of-range indices match no entry and read back as zero.
   always_comb begin
      rd_word = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (rd_idx == IDX_W'(k)) rd_word = regs[k];
      end
   end

   // NOTE: the register file is reset word by word because every control
   // word must come up at RESET_VALUE; it is flops, not an inferred RAM.
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         aw_held          <= 1'b0;
         w_held           <= 1'b0;
         aw_idx_q         <= '0;
         wdata_q          <= '0;
         wstrb_q          <= '0;
         reg_wr_stb       <= '0;
         axil.s_axi_bresp <= RESP_OKAY;
         for (int k = 0; k < NUM_REGS; k++) regs[k] <= RESET_VALUE;
      end else begin
         reg_wr_stb <= '0;
         if (aw_fire && !wr_done) begin
            aw_held  <= 1'b1;
            aw_idx_q <= axil.s_axi_awaddr[ADDR_WIDTH-1:2];
         end
         if (w_fire && !wr_done) begin
            w_held  <= 1'b1;
            wdata_q <= axil.s_axi_wdata;
            wstrb_q <= axil.s_axi_wstrb;
         end
         if (wr_done) begin
            aw_held          <= 1'b0;
            w_held           <= 1'b0;
            axil.s_axi_bresp <= wr_in_range ? RESP_OKAY : RESP_OOR;
            for (int k = 0; k < NUM_REGS; k++) begin
               if (wr_in_range && wr_idx == IDX_W'(k)) begin
                  reg_wr_stb[k] <= 1'b1;
                  for (int b = 0; b < 4; b++) begin
                     if (wr_strb[b]) regs[k][8*b +: 8] <= wr_data[8*b +: 8];
                  end
               end
            end
         end
      end
   end

   // Read data is sampled on the AR edge, so a same-edge write is not seen.
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         axil.s_axi_rdata <= '0;
         axil.s_axi_rresp <= RESP_OKAY;
      end else if (ar_fire) begin
         axil.s_axi_rdata <= rd_word;
         axil.s_axi_rresp <= rd_in_range ? RESP_OKAY : RESP_OOR;
      end
   end

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
      assign reg_out[32*k +: 32] = regs[k];
   end

endmodule

// File: tb/tb_audio_pipeline_axil_regs.sv
// Scoreboard bench for audio_pipeline_axil_regs: directed cases plus random
// traffic checked against an array model of the register file.
module tb_audio_pipeline_axil_regs;

   localparam int          AW      = 5;
   localparam int          NR      = 4;
   localparam logic [31:0] RST_VAL = 32'h5A5A_0000;
`ifdef AXIL_REGS_SLVERR_EN
   localparam logic [1:0] OOR_RESP = 2'b10;
`else
   localparam logic [1:0] OOR_RESP = 2'b00;
`endif

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
   } rd_exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic [NR*32-1:0] reg_out;
   logic [NR-1:0]    reg_wr_stb;

   audio_pipeline_axil_regs_if #(.ADDR_WIDTH(AW)) bus();

   audio_pipeline_axil_regs #(
      .ADDR_WIDTH (AW),
      .NUM_REGS   (NR),
      .RESET_VALUE(RST_VAL)
   ) dut (
      .ACLK      (clk),
      .ARESETN   (rst_n),
      .axil      (bus),
      .reg_out   (reg_out),
      .reg_wr_stb(reg_wr_stb)
   );

   always #5 clk = ~clk;

   logic [31:0] model [NR];
   logic [NR-1:0] exp_stb = '0;
   logic [1:0]  exp_b [$];
   rd_exp_t     exp_r [$];
   int          n_cmp = 0;
   int          n_err = 0;
   bit          mon_en = 1'b0;
   logic [31:0] last_rdata = '0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   function automatic bit in_range(input logic [AW-1:0] a);
      return int'(a >> 2) < NR;
   endfunction

   function automatic logic [NR*32-1:0] model_packed();
      logic [NR*32-1:0] p;
      for (int k = 0; k < NR; k++) p[32*k +: 32] = model[k];
      return p;
   endfunction

   function automatic rd_exp_t model_read(input logic [AW-1:0] a);
      rd_exp_t e;
      if (in_range(a)) begin
         e.data = model[int'(a >> 2)];
         e.resp = 2'b00;
      end else begin
         e.data = 32'h0;
         e.resp = OOR_RESP;
      end
      return e;
   endfunction

   task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] mask;
      int idx;
      if (!in_range(a)) return;
      idx  = int'(a >> 2);
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      model[idx] = (model[idx] & ~mask) | (d & mask);
      exp_stb = NR'(1) << idx;
   endtask

   // Monitor: register outputs every cycle, responses on each handshake.
   always @(negedge clk) begin
      if (mon_en) begin
         check("reg_out", reg_out, model_packed());
         check("reg_wr_stb", reg_wr_stb, exp_stb);
         exp_stb = '0;
         if (rst_n && bus.s_axi_bvalid && bus.s_axi_bready) begin
            if (exp_b.size() == 0) fail_now("b_unexpected");
            else check("bresp", bus.s_axi_bresp, exp_b.pop_front());
         end
         if (rst_n && bus.s_axi_rvalid && bus.s_axi_rready) begin
            if (exp_r.size() == 0) fail_now("r_unexpected");
            else begin
               rd_exp_t e;
               e = exp_r.pop_front();
               check("rdata", bus.s_axi_rdata, e.data);
               check("rresp", bus.s_axi_rresp, e.resp);
               last_rdata = bus.s_axi_rdata;
            end
         end
      end
   end

   task automatic axil_write(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input int b_dly);
      bit aw_done = 0, w_done = 0, aw_hs, w_hs, b_done = 0;
      int cyc = 0;
      logic [1:0] eresp;
      eresp = in_range(addr) ? 2'b00 : OOR_RESP;
      bus.s_axi_awaddr = addr;
      bus.s_axi_awprot = 3'($urandom);
      bus.s_axi_wdata  = data;
      bus.s_axi_wstrb  = strb;
      while (!(aw_done && w_done)) begin
         bus.s_axi_awvalid = !aw_done && cyc >= aw_dly;
         bus.s_axi_wvalid  = !w_done && cyc >= w_dly;
         @(negedge clk);
         if (w_done && !aw_done) check("wready_low_after_w", bus.s_axi_wready, 1'b0);
         if (aw_done && !w_done) check("awready_low_after_aw", bus.s_axi_awready, 1'b0);
         aw_hs = bus.s_axi_awvalid && bus.s_axi_awready;
         w_hs  = bus.s_axi_wvalid && bus.s_axi_wready;
         @(posedge clk);
         #1;
         aw_done |= aw_hs;
         w_done  |= w_hs;
         cyc++;
         if (cyc > 100) begin
            fail_now("write_addr_data_timeout");
            break;
         end
      end
      bus.s_axi_awvalid = 1'b0;
      bus.s_axi_wvalid  = 1'b0;
      if (!(aw_done && w_done)) return;
      model_write(addr, data, strb);
      exp_b.push_back(eresp);
      bus.s_axi_bready = (b_dly == 0);
      cyc = 0;
      while (!b_done) begin
         @(negedge clk);
         check("bvalid", bus.s_axi_bvalid, 1'b1);
         if (!bus.s_axi_bready) begin
            check("b_stall_bresp", bus.s_axi_bresp, eresp);
            check("b_stall_awready", bus.s_axi_awready, 1'b0);
            check("b_stall_wready", bus.s_axi_wready, 1'b0);
         end
         b_done = bus.s_axi_bvalid && bus.s_axi_bready;
         @(posedge clk);
         #1;
         cyc++;
         if (cyc >= b_dly) bus.s_axi_bready = 1'b1;
         if (!b_done && cyc > 100) begin
            fail_now("write_resp_timeout");
            break;
         end
      end
      bus.s_axi_bready = 1'b0;
   endtask

   task automatic axil_read(input logic [AW-1:0] addr, input int ar_dly, input int r_dly);
      bit hs = 0, r_done = 0;
      int cyc = 0;
      rd_exp_t e;
      bus.s_axi_araddr = addr;
      bus.s_axi_arprot = 3'($urandom);
      while (!hs) begin
         bus.s_axi_arvalid = cyc >= ar_dly;
         @(negedge clk);
         hs = bus.s_axi_arvalid && bus.s_axi_arready;
         if (hs) begin
            e = model_read(addr);
            exp_r.push_back(e);
         end
         @(posedge clk);
         #1;
         cyc++;
         if (!hs && cyc > 100) begin
            fail_now("read_addr_timeout");
            break;
         end
      end
      bus.s_axi_arvalid = 1'b0;
      if (!hs) return;
      bus.s_axi_rready = (r_dly == 0);
      cyc = 0;
      while (!r_done) begin
         @(negedge clk);
         check("rvalid", bus.s_axi_rvalid, 1'b1);
         if (!bus.s_axi_rready) begin
            check("r_stall_rdata", bus.s_axi_rdata, e.data);
            check("r_stall_rresp", bus.s_axi_rresp, e.resp);
            check("r_stall_arready", bus.s_axi_arready, 1'b0);
         end
         r_done = bus.s_axi_rvalid && bus.s_axi_rready;
         @(posedge clk);
         #1;
         cyc++;
         if (cyc >= r_dly) bus.s_axi_rready = 1'b1;
         if (!r_done && cyc > 100) begin
            fail_now("read_data_timeout");
            break;
         end
      end
      bus.s_axi_rready = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_awready"}, bus.s_axi_awready, 1'b1);
      check({tag, "_wready"},  bus.s_axi_wready,  1'b1);
      check({tag, "_arready"}, bus.s_axi_arready, 1'b1);
      check({tag, "_bvalid"},  bus.s_axi_bvalid,  1'b0);
      check({tag, "_rvalid"},  bus.s_axi_rvalid,  1'b0);
   endtask

   initial begin
      logic [AW-1:0] a;
      rst_n = 1'b0;
      bus.s_axi_awaddr = '0; bus.s_axi_awprot = '0; bus.s_axi_awvalid = 1'b0;
      bus.s_axi_wdata  = '0; bus.s_axi_wstrb  = '0; bus.s_axi_wvalid  = 1'b0;
      bus.s_axi_bready = 1'b0;
      bus.s_axi_araddr = '0; bus.s_axi_arprot = '0; bus.s_axi_arvalid = 1'b0;
      bus.s_axi_rready = 1'b0;
      for (int k = 0; k < NR; k++) model[k] = RST_VAL;
      repeat (3) @(posedge clk);
      #1;
      mon_en = 1'b1;
      @(negedge clk);
      check_idle_outputs("reset");
      check("reset_bresp", bus.s_axi_bresp, 2'b00);
      check("reset_rresp", bus.s_axi_rresp, 2'b00);
      check("reset_rdata", bus.s_axi_rdata, 32'h0);
      check("reset_regs", reg_out, {NR{RST_VAL}});
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Sequential fill and readback.
      for (int i = 0; i < NR; i++) axil_write(AW'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
      check("fill_reg_out", reg_out, {32'h4, 32'h3, 32'h2, 32'h1});
      for (int i = 0; i < NR; i++) axil_read(AW'(4 * i), 0, 0);
      check("fill_last_rdata", last_rdata, 32'h4);

      // W leads AW by three cycles.
      axil_write(5'h08, 32'hDEADBEEF, 4'hF, 3, 0, 0);
      check("w_first_reg2", reg_out[95:64], 32'hDEADBEEF);
      // AW leads W.
      axil_write(5'h0C, 32'hCAFEF00D, 4'hF, 0, 2, 0);

      // Partial byte strobes.
      axil_write(5'h04, 32'h11223344, 4'hF, 0, 0, 0);
      axil_write(5'h04, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
      check("strb_reg1", reg_out[63:32], 32'h11BB33DD);
      axil_read(5'h04, 0, 0);
      check("strb_read", last_rdata, 32'h11BB33DD);
      axil_write(5'h00, 32'h12345678, 4'b0000, 0, 0, 0);

      // Response back-pressure.
      axil_write(5'h00, 32'h0BADF00D, 4'hF, 0, 0, 5);
      axil_read(5'h00, 0, 5);

      // Same-edge write and read of one register.
      axil_write(5'h04, 32'h5, 4'hF, 0, 0, 0);
      fork
         axil_write(5'h04, 32'h9, 4'hF, 0, 0, 0);
         axil_read(5'h04, 0, 0);
      join
      check("same_edge_old", last_rdata, 32'h5);
      axil_read(5'h04, 0, 0);
      check("same_edge_new", last_rdata, 32'h9);

      // Out-of-range accesses.
      axil_write(5'h10, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
      axil_read(5'h14, 0, 1);
      check("oor_read_data", last_rdata, 32'h0);

      // Random traffic.
      for (int i = 0; i < 60; i++) begin
         a = AW'($urandom);
         if ($urandom_range(0, 3) != 0) a[AW-1] = 1'b0;
         case ($urandom_range(0, 2))
            0: axil_write(a, $urandom, 4'($urandom), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3));
            1: axil_read(a, $urandom_range(0, 3), $urandom_range(0, 3));
            default: begin
               logic [AW-1:0] a2;
               a2 = AW'($urandom_range(0, NR - 1) * 4);
               fork
                  axil_write(a2, $urandom, 4'hF, 0, $urandom_range(0, 2), $urandom_range(0, 2));
                  axil_read(a2, $urandom_range(0, 2), $urandom_range(0, 2));
               join
            end
         endcase
      end

      // Reset while a read response is pending.
      bus.s_axi_araddr  = 5'h08;
      bus.s_axi_arvalid = 1'b1;
      @(posedge clk);
      #1;
      bus.s_axi_arvalid = 1'b0;
      @(negedge clk);
      check("pre_reset_rvalid", bus.s_axi_rvalid, 1'b1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      for (int k = 0; k < NR; k++) model[k] = RST_VAL;
      exp_b.delete();
      exp_r.delete();
      @(negedge clk);
      check_idle_outputs("midreset");
      check("midreset_regs", reg_out, {NR{RST_VAL}});
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      axil_read(5'h08, 0, 0);
      check("post_reset_read", last_rdata, RST_VAL);

      repeat (3) @(posedge clk);
      #1;
      check("b_queue_drained", exp_b.size(), 0);
      check("r_queue_drained", exp_r.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
